// File: rtl/prio_enc_pkg.sv
// Shared types and defaults for the IRQ priority encoder.
// Holds the FSM state encoding and the default request count.
package prio_enc_pkg;

  localparam int PRIO_N_DEFAULT = 8;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

endpackage

// File: rtl/prio_find.sv
// Combinational highest-set-bit finder.
// Reports the top set index of vec and whether any bit is set.
module prio_find #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan: the last hit is the highest index.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_priority_encoder.sv
// Latches IRQ requests and presents one grant at a time over valid/ready.
// Fixed priority by default; PRIO_ENC_RR_EN selects round-robin.
module irq_priority_encoder
  import prio_enc_pkg::*;
#(
  parameter  int N = PRIO_N_DEFAULT,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending
);

  state_t       state;
  logic [N-1:0] elig;
  logic [N-1:0] clr;
  logic [W-1:0] sel;
  logic         any;
  logic         hs;

  assign elig = pending & mask;
  assign hs   = out_valid & out_ready;
  assign clr  = hs ? (N'(1) << out_idx) : '0;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] last_idx;
  logic [N-1:0] rot;
  logic [W-1:0] rot_idx;
  logic [W:0]   sum;

  // Rotate so bit (last_idx-1) mod N lands on top; descending
  // search over rot then equals the wrapped search over elig.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = elig[(i + int'(last_idx)) % N];
    end
  end

  prio_find #(.N(N), .W(W)) u_find (
    .vec (rot),
    .idx (rot_idx),
    .any (any)
  );

  assign sum = {1'b0, rot_idx} + {1'b0, last_idx};
  assign sel = (sum >= (W+1)'(N)) ?
               W'(sum - (W+1)'(N)) : sum[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx <= '0;
    end else if (hs) begin
      last_idx <= out_idx;
    end
  end
`else
  prio_find #(.N(N), .W(W)) u_find (
    .vec (elig),
    .idx (sel),
    .any (any)
  );
`endif

  // Set wins over clear on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            out_idx   <= sel;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Self-checking bench for irq_priority_encoder (N=8).
// Reference model follows PRIO_ENC_RR_EN when defined.
module tb_irq_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] mask = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  bit [N-1:0] mp;
  bit         mv;
  int         mi;
  int         mlast;

  irq_priority_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mp = '0;
    mv = 0;
    mi = 0;
    mlast = 0;
  endtask

  // Pick the eligible line according to the selection rule.
  function automatic int pick(input bit [N-1:0] p, input bit [N-1:0] m);
    int start;
    int k;
`ifdef PRIO_ENC_RR_EN
    start = (mlast + N - 1) % N;
`else
    start = N - 1;
`endif
    for (int t = 0; t < N; t++) begin
      k = (start - t + N) % N;
      if (p[k] && m[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_edge(input bit [N-1:0] r, input bit [N-1:0] m,
                            input bit rd);
    bit [N-1:0] np;
    int c;
    np = mp;
    if (mv && rd) begin
      np[mi] = 1'b0;
      mlast = mi;
      mv = 0;
    end else if (!mv) begin
      c = pick(mp, m);
      if (c >= 0) begin
        mv = 1;
        mi = c;
      end
    end
    mp = np | r;
  endtask

  task automatic check_model();
    cmp("valid", 32'(out_valid), 32'(mv));
    cmp("idx", 32'(out_idx), 32'(mi));
    cmp("pending", 32'(pending), 32'(mp));
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] m,
                      input logic rd);
    req = r;
    mask = m;
    out_ready = rd;
    @(posedge clk);
    model_edge(r, m, rd);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    cmp("rst_valid", 32'(out_valid), 32'd0);
    cmp("rst_idx", 32'(out_idx), 32'd0);
    cmp("rst_pending", 32'(pending), 32'd0);
    model_reset();
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_g[$];
    int got;
    int guard;

    model_reset();
    #2;
    do_reset();

    // Fixed ordering: 5 then 3 with one bubble
    step(8'b0010_1000, 8'hFF, 1'b1);
    cmp("ord_pend", 32'(pending), 32'h28);
    step(8'h00, 8'hFF, 1'b1);
    cmp("ord_g5", 32'(out_idx), 32'd5);
    step(8'h00, 8'hFF, 1'b1);
    cmp("ord_bubble", 32'(out_valid), 32'd0);
    step(8'h00, 8'hFF, 1'b1);
    cmp("ord_g3", 32'(out_idx), 32'd3);
    step(8'h00, 8'hFF, 1'b1);
    cmp("ord_done_p", 32'(pending), 32'h00);
    cmp("ord_done_v", 32'(out_valid), 32'd0);

    // Backpressure
    step(8'h01, 8'hFF, 1'b0);
    step(8'h80, 8'hFF, 1'b0);
    cmp("bp_idx0", 32'(out_idx), 32'd0);
    cmp("bp_p81", 32'(pending), 32'h81);
    step(8'h00, 8'hFF, 1'b0);
    cmp("bp_hold", 32'(out_idx), 32'd0);
    step(8'h00, 8'hFF, 1'b1);
    cmp("bp_p80", 32'(pending), 32'h80);
    step(8'h00, 8'hFF, 1'b1);
    cmp("bp_g7", 32'(out_idx), 32'd7);
    step(8'h00, 8'hFF, 1'b1);
    cmp("bp_p00", 32'(pending), 32'h00);

    // Mask retains bits without granting
    step(8'hF0, 8'h0F, 1'b1);
    step(8'h00, 8'h0F, 1'b1);
    cmp("mask_v", 32'(out_valid), 32'd0);
    cmp("mask_p", 32'(pending), 32'hF0);
    step(8'h00, 8'hFF, 1'b1);
    cmp("mask_g7", 32'(out_idx), 32'd7);
    for (int i = 0; i < 10; i++) step(8'h00, 8'hFF, 1'b1);

    // Set/clear collision on bit 5
    do_reset();
    step(8'h20, 8'hFF, 1'b1);
    step(8'h20, 8'hFF, 1'b1);
    cmp("col_g5", 32'(out_idx), 32'd5);
    step(8'h20, 8'hFF, 1'b1);
    cmp("col_keep", 32'(pending), 32'h20);
    step(8'h20, 8'hFF, 1'b1);
    cmp("col_regrant", 32'(out_idx), 32'd5);
    cmp("col_regrant_v", 32'(out_valid), 32'd1);

    // Grant sequence with all lines held
    do_reset();
`ifdef PRIO_ENC_RR_EN
    exp_g = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
    exp_g = '{7, 7, 7};
`endif
    got = 0;
    guard = 0;
    while (got < exp_g.size() && guard < 40) begin
      step(8'hFF, 8'hFF, 1'b1);
      if (out_valid) begin
        cmp("seq_grant", 32'(out_idx), 32'(exp_g[got]));
        got++;
      end
      guard++;
    end
    cmp("seq_count", 32'(got), 32'(exp_g.size()));

    // Reset mid-PRESENT, then latch at first edge after release
    do_reset();
    step(8'h04, 8'hFF, 1'b0);
    step(8'h00, 8'hFF, 1'b0);
    cmp("pre_rst_v", 32'(out_valid), 32'd1);
    do_reset();
    step(8'h02, 8'hFF, 1'b0);
    cmp("post_rst_p", 32'(pending), 32'h02);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      logic [N-1:0] m;
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      m = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
      step(r, m, 1'($urandom_range(0, 2) != 0));
      if (i == 200) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
